// File: rtl/wb_unit.sv
// wb_unit: MEM->WB stage register with load formatting, result select and register-file write port.
// Latency: 1 cycle from accept to rf_we_o; throughput 1 instruction/cycle.
// Backpressure: mem_ready_o drops only while a held instruction is stalled; WB_INSTRET_EN adds the 64-bit retire counter.
module wb_unit #(
    parameter int XLEN = 32,
    parameter int RAW  = 5,
    parameter int OFFW = $clog2(XLEN/8)
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic [RAW-1:0]  mem_rd_i,
    input  logic            mem_rd_we_i,
    input  logic [1:0]      mem_sel_i,
    input  logic [XLEN-1:0] mem_alu_i,
    input  logic [XLEN-1:0] mem_pc_i,
    input  logic [XLEN-1:0] mem_csr_i,
    input  logic [XLEN-1:0] mem_ldata_i,
    input  logic [2:0]      mem_ltype_i,
    input  logic [OFFW-1:0] mem_off_i,

    input  logic            wb_stall_i,
    input  logic            flush_i,

    output logic            rf_we_o,
    output logic [RAW-1:0]  rf_waddr_o,
    output logic [XLEN-1:0] rf_wdata_o,
    output logic            retire_o,
    output logic [63:0]     instret_o
);

    logic            valid_q;
    logic [RAW-1:0]  rd_q;
    logic            we_q;
    logic [XLEN-1:0] data_q;

    logic            take;
    logic            retire;
    logic [OFFW-1:0] off_w;
    logic [7:0]      byte_v;
    logic [15:0]     half_v;
    logic [31:0]     word_v;
    logic [XLEN-1:0] ld_fmt;
    logic [XLEN-1:0] result;

    assign mem_ready_o = ~valid_q | ~wb_stall_i;
    assign take        = mem_valid_i & mem_ready_o & ~flush_i;
    assign retire      = valid_q & ~wb_stall_i;

    // Offset bits below the access size are dropped; misalignment is caught upstream.
    assign off_w  = mem_off_i & ~OFFW'(3);
    assign byte_v = mem_ldata_i[{mem_off_i, 3'b000} +: 8];
    assign half_v = mem_ldata_i[{mem_off_i[OFFW-1:1], 4'b0000} +: 16];
    assign word_v = mem_ldata_i[{off_w, 3'b000} +: 32];

    always_comb begin
        ld_fmt = '0;
        case (mem_ltype_i)
            3'b000:  ld_fmt = XLEN'($signed(byte_v));
            3'b001:  ld_fmt = XLEN'($signed(half_v));
            3'b010:  ld_fmt = XLEN'($signed(word_v));
            3'b100:  ld_fmt = XLEN'(byte_v);
            3'b101:  ld_fmt = XLEN'(half_v);
            default: begin
                // 011/110/111: doubleword forms on RV64, plain LW on RV32.
                if (XLEN == 64) begin
                    if (mem_ltype_i == 3'b110) ld_fmt = XLEN'(word_v);
                    else                       ld_fmt = mem_ldata_i;
                end else begin
                    ld_fmt = XLEN'($signed(word_v));
                end
            end
        endcase
    end

    always_comb begin
        result = mem_alu_i;
        case (mem_sel_i)
            2'b00:   result = mem_alu_i;
            2'b01:   result = ld_fmt;
            2'b10:   result = mem_pc_i + XLEN'(4);
            default: result = mem_csr_i;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rd_q    <= '0;
            we_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            if (take) begin
                valid_q <= 1'b1;
                rd_q    <= mem_rd_i;
                we_q    <= mem_rd_we_i;
                data_q  <= result;
            end else if (retire) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign retire_o   = retire;
    assign rf_we_o    = retire & we_q & (rd_q != '0);
    assign rf_waddr_o = rd_q;
    assign rf_wdata_o = data_q;

`ifdef WB_INSTRET_EN
    logic [63:0] instret_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_q <= '0;
        end else if (retire) begin
            instret_q <= instret_q + 64'd1;
        end
    end

    assign instret_o = instret_q;
`else
    assign instret_o = 64'd0;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Directed bench for wb_unit: table of single-instruction vectors plus stall, flush and reset sequences.
module tb_wb_unit;
    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int OFFW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            mem_valid_i;
    logic            mem_ready_o;
    logic [RAW-1:0]  mem_rd_i;
    logic            mem_rd_we_i;
    logic [1:0]      mem_sel_i;
    logic [XLEN-1:0] mem_alu_i;
    logic [XLEN-1:0] mem_pc_i;
    logic [XLEN-1:0] mem_csr_i;
    logic [XLEN-1:0] mem_ldata_i;
    logic [2:0]      mem_ltype_i;
    logic [OFFW-1:0] mem_off_i;
    logic            wb_stall_i;
    logic            flush_i;
    logic            rf_we_o;
    logic [RAW-1:0]  rf_waddr_o;
    logic [XLEN-1:0] rf_wdata_o;
    logic            retire_o;
    logic [63:0]     instret_o;

    always #5 clk = ~clk;

    wb_unit #(.XLEN(XLEN), .RAW(RAW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .mem_rd_i    (mem_rd_i),
        .mem_rd_we_i (mem_rd_we_i),
        .mem_sel_i   (mem_sel_i),
        .mem_alu_i   (mem_alu_i),
        .mem_pc_i    (mem_pc_i),
        .mem_csr_i   (mem_csr_i),
        .mem_ldata_i (mem_ldata_i),
        .mem_ltype_i (mem_ltype_i),
        .mem_off_i   (mem_off_i),
        .wb_stall_i  (wb_stall_i),
        .flush_i     (flush_i),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .retire_o    (retire_o),
        .instret_o   (instret_o)
    );

    typedef struct {
        logic [1:0]  sel;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] csr;
        logic [31:0] ldata;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic        exp_we;
        logic [31:0] exp_d;
    } vec_t;

    vec_t vt[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_ret  = 0;

    // Negedge monitor: every retire pulse and every register-file write.
    int          mon_ret = 0;
    logic [36:0] wq[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (retire_o) mon_ret++;
            if (rf_we_o) wq.push_back({rf_waddr_o, rf_wdata_o});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] exp_cnt(input int n);
`ifdef WB_INSTRET_EN
        return 64'(n);
`else
        return 64'(n) & 64'd0;
`endif
    endfunction

    function automatic vec_t mk(input logic [1:0] sel, input logic [4:0] rd, input logic we,
                                input logic [31:0] alu, input logic [31:0] pc, input logic [31:0] csr,
                                input logic [31:0] ldata, input logic [2:0] lt, input logic [1:0] off,
                                input logic exp_we, input logic [31:0] exp_d);
        vec_t v;
        v.sel = sel; v.rd = rd; v.we = we; v.alu = alu; v.pc = pc; v.csr = csr;
        v.ldata = ldata; v.lt = lt; v.off = off; v.exp_we = exp_we; v.exp_d = exp_d;
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        mem_valid_i = 1'b1;
        mem_sel_i   = v.sel;
        mem_rd_i    = v.rd;
        mem_rd_we_i = v.we;
        mem_alu_i   = v.alu;
        mem_pc_i    = v.pc;
        mem_csr_i   = v.csr;
        mem_ldata_i = v.ldata;
        mem_ltype_i = v.lt;
        mem_off_i   = v.off;
    endtask

    task automatic alu_op(input logic [4:0] rd, input logic [31:0] val);
        drive(mk(2'b00, rd, 1'b1, val, 32'h0, 32'h0, 32'h0, 3'b000, 2'b00, 1'b1, val));
    endtask

    initial begin
        int ret_base;
        int wq_base;

        rst_n = 1'b0;
        mem_valid_i = 1'b0; mem_rd_i = '0; mem_rd_we_i = 1'b0; mem_sel_i = 2'b00;
        mem_alu_i = '0; mem_pc_i = '0; mem_csr_i = '0; mem_ldata_i = '0;
        mem_ltype_i = 3'b000; mem_off_i = '0; wb_stall_i = 1'b0; flush_i = 1'b0;

        vt.push_back(mk(2'b00, 5'd3,  1'b1, 32'h0000_1234, 32'h0, 32'h0, 32'h0,         3'b000, 2'd0, 1'b1, 32'h0000_1234));
        vt.push_back(mk(2'b01, 5'd4,  1'b1, 32'h0,         32'h0, 32'h0, 32'h80FF_7F01, 3'b000, 2'd2, 1'b1, 32'hFFFF_FFFF));
        vt.push_back(mk(2'b01, 5'd5,  1'b1, 32'h0,         32'h0, 32'h0, 32'h80FF_7F01, 3'b101, 2'd2, 1'b1, 32'h0000_80FF));
        vt.push_back(mk(2'b01, 5'd6,  1'b1, 32'h0,         32'h0, 32'h0, 32'h80FF_7F01, 3'b001, 2'd0, 1'b1, 32'h0000_7F01));
        vt.push_back(mk(2'b01, 5'd7,  1'b1, 32'h0,         32'h0, 32'h0, 32'h80FF_7F01, 3'b000, 2'd0, 1'b1, 32'h0000_0001));
        vt.push_back(mk(2'b01, 5'd8,  1'b1, 32'h0,         32'h0, 32'h0, 32'h80FF_7F01, 3'b000, 2'd3, 1'b1, 32'hFFFF_FF80));
        vt.push_back(mk(2'b01, 5'd9,  1'b1, 32'h0,         32'h0, 32'h0, 32'h80FF_7F01, 3'b100, 2'd3, 1'b1, 32'h0000_0080));
        vt.push_back(mk(2'b01, 5'd10, 1'b1, 32'h0,         32'h0, 32'h0, 32'h80FF_7F01, 3'b001, 2'd3, 1'b1, 32'hFFFF_80FF));
        vt.push_back(mk(2'b01, 5'd11, 1'b1, 32'h0,         32'h0, 32'h0, 32'h80FF_7F01, 3'b010, 2'd1, 1'b1, 32'h80FF_7F01));
        vt.push_back(mk(2'b01, 5'd12, 1'b1, 32'h0,         32'h0, 32'h0, 32'h1234_5678, 3'b011, 2'd0, 1'b1, 32'h1234_5678));
        vt.push_back(mk(2'b01, 5'd13, 1'b1, 32'h0,         32'h0, 32'h0, 32'h8765_4321, 3'b110, 2'd0, 1'b1, 32'h8765_4321));
        vt.push_back(mk(2'b01, 5'd14, 1'b1, 32'h0,         32'h0, 32'h0, 32'hCAFE_F00D, 3'b111, 2'd2, 1'b1, 32'hCAFE_F00D));
        vt.push_back(mk(2'b10, 5'd15, 1'b1, 32'h0,         32'hFFFF_FFFC, 32'h0, 32'h0, 3'b000, 2'd0, 1'b1, 32'h0000_0000));
        vt.push_back(mk(2'b10, 5'd16, 1'b1, 32'h0,         32'h0000_0100, 32'h0, 32'h0, 3'b000, 2'd0, 1'b1, 32'h0000_0104));
        vt.push_back(mk(2'b11, 5'd17, 1'b1, 32'h0,         32'h0, 32'hDEAD_BEEF, 32'h0, 3'b000, 2'd0, 1'b1, 32'hDEAD_BEEF));
        vt.push_back(mk(2'b00, 5'd0,  1'b1, 32'h0000_0005, 32'h0, 32'h0, 32'h0,         3'b000, 2'd0, 1'b0, 32'h0000_0005));
        vt.push_back(mk(2'b00, 5'd7,  1'b0, 32'h0000_0077, 32'h0, 32'h0, 32'h0,         3'b000, 2'd0, 1'b0, 32'h0000_0077));

        #3;
        chk("reset rf_we", 64'(rf_we_o), 64'd0);
        chk("reset waddr", 64'(rf_waddr_o), 64'd0);
        chk("reset wdata", 64'(rf_wdata_o), 64'd0);
        chk("reset retire", 64'(retire_o), 64'd0);
        chk("reset instret", instret_o, 64'd0);
        chk("reset ready", 64'(mem_ready_o), 64'd1);
        tick; tick;
        rst_n = 1'b1;

        // Table vectors are driven back to back; each is checked the cycle after its accept.
        foreach (vt[i]) begin
            drive(vt[i]);
            tick;
            chk($sformatf("v%0d retire", i), 64'(retire_o), 64'd1);
            chk($sformatf("v%0d rf_we", i), 64'(rf_we_o), 64'(vt[i].exp_we));
            chk($sformatf("v%0d waddr", i), 64'(rf_waddr_o), 64'(vt[i].rd));
            chk($sformatf("v%0d wdata", i), 64'(rf_wdata_o), 64'(vt[i].exp_d));
            n_ret++;
        end
        mem_valid_i = 1'b0;
        tick;
        chk("idle retire", 64'(retire_o), 64'd0);
        chk("table instret", instret_o, exp_cnt(n_ret));

        // Three instructions, second one stalled for two cycles.
        ret_base = mon_ret; wq_base = wq.size();
        alu_op(5'd1, 32'h11);
        tick;
        chk("stall I1 waddr", 64'(rf_waddr_o), 64'd1);
        alu_op(5'd2, 32'h22);
        tick;
        wb_stall_i = 1'b1;
        alu_op(5'd3, 32'h33);
        #1;
        chk("stall c1 ready", 64'(mem_ready_o), 64'd0);
        chk("stall c1 retire", 64'(retire_o), 64'd0);
        chk("stall c1 rf_we", 64'(rf_we_o), 64'd0);
        tick;
        chk("stall c2 ready", 64'(mem_ready_o), 64'd0);
        chk("stall c2 waddr", 64'(rf_waddr_o), 64'd2);
        chk("stall c2 wdata", 64'(rf_wdata_o), 64'h22);
        tick;
        wb_stall_i = 1'b0;
        #1;
        chk("unstall ready", 64'(mem_ready_o), 64'd1);
        chk("unstall retire", 64'(retire_o), 64'd1);
        tick;
        mem_valid_i = 1'b0;
        chk("I3 waddr", 64'(rf_waddr_o), 64'd3);
        chk("I3 wdata", 64'(rf_wdata_o), 64'h33);
        tick;
        chk("stall seq drained", 64'(retire_o), 64'd0);
        n_ret += 3;
        chk("stall seq pulses", 64'(mon_ret - ret_base), 64'd3);
        chk("stall seq writes", 64'(wq.size() - wq_base), 64'd3);
        if (wq.size() - wq_base == 3) begin
            chk("stall seq w0", 64'(wq[wq_base]),     64'({5'd1, 32'h11}));
            chk("stall seq w1", 64'(wq[wq_base + 1]), 64'({5'd2, 32'h22}));
            chk("stall seq w2", 64'(wq[wq_base + 2]), 64'({5'd3, 32'h33}));
        end
        chk("stall seq instret", instret_o, exp_cnt(n_ret));

        // Flush of the incoming instruction while the stage holds one.
        ret_base = mon_ret; wq_base = wq.size();
        alu_op(5'd4, 32'h44);
        tick;
        alu_op(5'd5, 32'h55);
        flush_i = 1'b1;
        #1;
        chk("flush held retire", 64'(retire_o), 64'd1);
        chk("flush held waddr", 64'(rf_waddr_o), 64'd4);
        tick;
        flush_i = 1'b0;
        mem_valid_i = 1'b0;
        #1;
        chk("flush no capture", 64'(retire_o), 64'd0);
        chk("flush no write", 64'(rf_we_o), 64'd0);
        tick; tick;
        n_ret += 1;
        chk("flush writes", 64'(wq.size() - wq_base), 64'd1);
        chk("flush pulses", 64'(mon_ret - ret_base), 64'd1);
        chk("flush instret", instret_o, exp_cnt(n_ret));

        // Reset asserted mid-cycle while an instruction is held under stall.
        ret_base = mon_ret; wq_base = wq.size();
        alu_op(5'd6, 32'h66);
        tick;
        mem_valid_i = 1'b0;
        wb_stall_i = 1'b1;
        #1;
        chk("pre-reset held", 64'(rf_waddr_o), 64'd6);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst rf_we", 64'(rf_we_o), 64'd0);
        chk("arst waddr", 64'(rf_waddr_o), 64'd0);
        chk("arst wdata", 64'(rf_wdata_o), 64'd0);
        chk("arst retire", 64'(retire_o), 64'd0);
        chk("arst instret", instret_o, 64'd0);
        chk("arst ready", 64'(mem_ready_o), 64'd1);
        tick;
        rst_n = 1'b1;
        wb_stall_i = 1'b0;
        tick; tick; tick;
        chk("post-reset writes", 64'(wq.size() - wq_base), 64'd0);
        chk("post-reset pulses", 64'(mon_ret - ret_base), 64'd0);
        chk("post-reset instret", instret_o, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 SHALL have parameter RAW, default 5, register-address width.
REQ-003 SHALL have derived parameter OFFW, equal to log2(XLEN/8), the byte-offset width.
REQ-004 SHALL have clk  in  1  single clock; all state on its rising edge.
REQ-005 SHALL have rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have mem_valid_i in 1 and mem_ready_o out 1 as the MEM→WB handshake.
REQ-007 SHALL have mem_rd_i in RAW (destination register) and mem_rd_we_i in 1 (writes register).
REQ-008 SHALL have mem_sel_i  in  2  result source: 00 ALU, 01 load, 10 PC+4, 11 CSR.
REQ-009 SHALL have data inputs mem_alu_i, mem_pc_i, mem_csr_i and mem_ldata_i, each in XLEN.
REQ-010 SHALL have mem_ltype_i in 3 (load funct3) and mem_off_i in OFFW (address low bits).
REQ-011 SHALL have wb_stall_i in 1 (hold WB) and flush_i in 1 (drop incoming instruction).
REQ-012 SHALL have rf_we_o out 1, rf_waddr_o out RAW and rf_wdata_o out XLEN as the register-file write port.
REQ-013 SHALL have retire_o  out  1  one-cycle pulse per retired instruction.
REQ-014 SHALL have instret_o  out  64  retired-instruction count.

Function
REQ-015 SHALL hold one instruction in a stage register: valid_q, rd_q, we_q, data_q.
REQ-016 SHALL drive mem_ready_o = ~valid_q | ~wb_stall_i, combinationally.
REQ-017 SHALL accept (capture) an instruction when mem_valid_i & mem_ready_o & ~flush_i.
REQ-018 SHALL, when flush_i is high, not capture the incoming instruction; an instruction already held in valid_q SHALL still retire normally.
REQ-019 SHALL retire the held instruction in any cycle with valid_q & ~wb_stall_i; retire_o = that condition.
REQ-020 SHALL update valid_q on retire: set to 1 if a capture occurs in the same cycle (back-to-back), otherwise clear to 0.
REQ-021 SHALL hold valid_q and all stage fields unchanged while valid_q & wb_stall_i.
REQ-022 SHALL drive rf_we_o = retire_o & we_q & (rd_q != 0); rf_waddr_o = rd_q; rf_wdata_o = data_q.
REQ-023 SHALL count an instruction writing x0 as retired, with rf_we_o low.
REQ-024 SHALL have latency of exactly 1 cycle from accept to rf_we_o when unstalled; throughput of 1 instruction/cycle.
REQ-025 SHALL format load data before capture (registered result), reading the field at byte offset mem_off_i of mem_ldata_i.
REQ-026 SHALL format loads by mem_ltype_i as follows: LB 000 sign-extend byte; LH 001 sign-extend halfword at offset[OFFW-1:1]; LW 010 word (sign-extended when XLEN=64); LBU 100 zero-extend byte; LHU 101 zero-extend halfword.
REQ-027 SHALL, when XLEN=64, format LD 011 as the full doubleword and LWU 110 as a zero-extended word.
REQ-028 SHALL treat mem_ltype_i 011, 110 and 111 as LW when XLEN=32, and 111 as LD when XLEN=64.
REQ-029 SHALL ignore offset bits below the access size; alignment is checked upstream.
REQ-030 SHALL compute PC+4 source as mem_pc_i + 4 modulo 2^XLEN, so 0xFFFFFFFC yields 0x00000000.

Reset
REQ-031 SHALL, while rst_n=0, clear valid_q, rd_q, we_q, data_q and instret to 0, so rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, retire_o=0 and instret_o=0.
REQ-032 SHALL, when reset is asserted mid-stall, lose the held instruction; it is not retired.
REQ-033 SHALL drive mem_ready_o=1 during reset, since valid_q=0.

Configuration
REQ-034 SHALL provide macro WB_INSTRET_EN.
REQ-035 SHALL, when WB_INSTRET_EN is defined, implement a 64-bit counter that increments by 1 on each retire_o and wraps from 2^64-1 to 0.
REQ-036 SHALL, when WB_INSTRET_EN is undefined, tie instret_o to 0 and instantiate no counter flops.

Verification
REQ-037 SHALL cover: ALU op with rd=3, alu=0x1234 accepted cycle N, no stall -> cycle N+1 rf_we_o=1, waddr=3, wdata=0x00001234, retire_o=1.
REQ-038 SHALL cover: LB, ldata=0x80FF7F01, off=2 -> wdata=0xFFFFFFFF; LHU, off=2 -> 0x000080FF; LH, off=0 -> 0x00007F01.
REQ-039 SHALL cover: 3 back-to-back instructions with wb_stall_i high 2 cycles on the second -> mem_ready_o low during stall, no loss or duplication, 3 retire pulses, instret_o=3 (WB_INSTRET_EN).
REQ-040 SHALL cover: instruction with rd=0, we=1 -> retire_o=1, rf_we_o=0; instret increments.
REQ-041 SHALL cover: flush_i with mem_valid_i high while WB holds instruction -> held instruction retires, incoming never writes.
REQ-042 SHALL cover: rst_n low while valid_q=1 and stalled -> all outputs 0 asynchronously; no write after release.
